xml_element_extractor: RTL
==========================

Name: xml_element_extractor

Overview:
- Sits directly downstream of the scanning XML decoder and consumes its annotated byte stream.
- Matches opening tags against a fixed element name at a fixed nesting depth.
- Streams out the direct text content of every matched element, then reports its length, a running match count and an abort flag.
- Output feeds field-level consumers such as number parsers and key capture.

Parameters:
- NAME, "price" (8*MAX_NAME bits, left-justified, first char in MSB byte): element name to match.
- NAME_LEN, 5: number of significant characters in NAME; 1..MAX_NAME.
- MAX_NAME, 16: capacity of the NAME string in characters.
- TARGET_DEPTH, 2: value of tagDepth while inside the matched element's content; 1..15.

Ports:
- CLOCK  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- inValid  in  1  decoder outValid.
- in  in  8  decoder out byte.
- inNewMsg  in  1  decoder outNewMsg.
- isTag  in  1  decoder isTag.
- isTagName  in  1  decoder isTagName; high on name bytes only, excluding '<' and '/'.
- isData  in  1  decoder isData.
- tagDepth  in  4  decoder tagDepth.
- depthPush  in  1  decoder depthPush; 1-cycle pulse on the cycle after an opening tag's '>'; tagDepth is already incremented on that cycle.
- depthPop  in  1  decoder depthPop; same timing as depthPush, for closing tags.
- outValid  out  1  content byte valid.
- out  out  8  content byte.
- outStart  out  1  marks the first content byte of an element.
- outEnd  out  1  1-cycle pulse when the element ends.
- outAbort  out  1  qualifies outEnd: the element was truncated by a new message.
- outLen  out  16  content byte count; valid while outEnd is high.
- matchCount  out  16  number of completed (non-aborted) elements since reset or newMsg.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0, state IDLE, counters 0. No synchronous reset input.
- Latency: all outputs are registered. A content byte presented on cycle t appears on out/outValid at t+1.
- No backpressure; every input byte is processed in the cycle it is presented.
- State IDLE:
  - inValid && isTagName: idx<=1, mis<=(in!=NAME[0]), go to NAME.
- State NAME:
  - inValid && isTagName: mis |= (idx>=NAME_LEN) || (in!=NAME[idx]); idx increments, saturating at MAX_NAME.
  - inValid && !isTagName (name run ended): go to ARMED if !mis && idx==NAME_LEN && tagDepth==TARGET_DEPTH-1; otherwise go to IDLE.
- State ARMED:
  - depthPush && tagDepth==TARGET_DEPTH: go to CAPTURE; len<=0; firstPending<=1.
  - depthPop, or inValid && !isTag without a push (self-closing or closing tag): go to IDLE, no output.
- State CAPTURE:
  - inValid && isData && tagDepth==TARGET_DEPTH: emit byte; outStart=firstPending, then clear firstPending; len increments, saturating at 0xFFFF.
  - Data inside child elements (tagDepth>TARGET_DEPTH) is not emitted. Child tags are ignored; no nested matching.
  - depthPop && tagDepth==TARGET_DEPTH-1: outEnd=1, outLen=len, outAbort=0; matchCount increments, wrapping at 16 bits; go to IDLE.
  - The same-cycle byte at the parent depth is not emitted.
  - An empty element gives outEnd with outLen=0 and no outValid.
- Comments: isTag and isData are low inside comments from the decoder, so no special handling is needed.
- inNewMsg (highest priority, any state):
  - Go to IDLE and clear matchCount.
  - If in CAPTURE: outEnd=1, outAbort=1, outLen=len; matchCount is not incremented.
  - A byte presented on the same cycle is not emitted.
- Simultaneity: depthPush and a data byte on the same cycle in ARMED → go to CAPTURE and also capture that byte if it meets the CAPTURE data condition, so it is the first byte with outStart=1.
- Single element in flight: no new match can begin until CAPTURE exits.

Test Plan:
- "<a><price>12.5</price></a>", NAME="price", TARGET_DEPTH=2 → out bytes '1','2','.','5'; outStart on '1'; outEnd with outLen=4, outAbort=0; matchCount=1.
- "<a><pricex>9</pricex><pric>8</pric></a>" → no outValid, no outEnd, matchCount=0 (longer and shorter names rejected).
- "<price>7</price>" at depth 1 with TARGET_DEPTH=2 → no output. "<a><price/><price>3</price></a>" → only '3' emitted; one outEnd with outLen=1.
- "<a><price>4<b>x</b>2</price></a>" → emits '4','2' only; outLen=2; 'x' suppressed.
- "<a><price>123" followed by inNewMsg pulse → '1','2','3' emitted, then outEnd=1, outAbort=1, outLen=3; matchCount=0.
- Empty "<a><price></price></a>", and reset_n asserted mid-CAPTURE → empty element gives outEnd with outLen=0; reset gives all outputs 0 immediately (asynchronous) and the next element is matched normally.

Source files
------------

// File: rtl/xml_element_extractor.sv
// Extracts the direct text content of elements named NAME found at nesting depth TARGET_DEPTH
// in the annotated byte stream from the scanning XML decoder.
module xml_element_extractor #(
   parameter int unsigned             MAX_NAME     = 16,
   parameter logic [8*MAX_NAME-1:0]   NAME         = {"price", {(8*MAX_NAME-40){1'b0}}},
   parameter int unsigned             NAME_LEN     = 5,
   parameter int unsigned             TARGET_DEPTH = 2
) (
   input  logic        CLOCK,
   input  logic        reset_n,
   input  logic        inValid,
   input  logic [7:0]  in,
   input  logic        inNewMsg,
   input  logic        isTag,
   input  logic        isTagName,
   input  logic        isData,
   input  logic [3:0]  tagDepth,
   input  logic        depthPush,
   input  logic        depthPop,
   output logic        outValid,
   output logic [7:0]  out,
   output logic        outStart,
   output logic        outEnd,
   output logic        outAbort,
   output logic [15:0] outLen,
   output logic [15:0] matchCount
);

   localparam int unsigned IdxW     = $clog2(MAX_NAME + 1);
   localparam logic [3:0]  DepthIn  = 4'(TARGET_DEPTH);
   localparam logic [3:0]  DepthOut = 4'(TARGET_DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StName, StArmed, StCapture} state_e;

   state_e            r_state;
   logic [IdxW-1:0]   r_idx;
   logic              r_mis;
   logic              r_first;
   logic [15:0]       r_len;
   logic              r_out_valid;
   logic [7:0]        r_out;
   logic              r_out_start;
   logic              r_out_end;
   logic              r_out_abort;
   logic [15:0]       r_out_len;
   logic [15:0]       r_match_cnt;

   logic [7:0]        w_name_char;
   logic [7:0]        w_first_char;
   logic              w_data_hit;
   logic              w_name_ok;

   // Character of NAME at position r_idx; positions beyond the buffer read as NUL.
   always_comb begin
      w_name_char = 8'h00;
      for (int k = 0; k < int'(MAX_NAME); k++) begin
         if (r_idx == IdxW'(k)) w_name_char = NAME[8*(int'(MAX_NAME)-1-k) +: 8];
      end
   end

   assign w_first_char = NAME[8*MAX_NAME-1 -: 8];
   assign w_data_hit   = inValid && isData && (tagDepth == DepthIn);
   assign w_name_ok    = !r_mis && (r_idx == IdxW'(NAME_LEN)) && (tagDepth == DepthOut);

   always_ff @(posedge CLOCK or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_idx       <= '0;
         r_mis       <= 1'b0;
         r_first     <= 1'b0;
         r_len       <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_out_start <= 1'b0;
         r_out_end   <= 1'b0;
         r_out_abort <= 1'b0;
         r_out_len   <= '0;
         r_match_cnt <= '0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_start <= 1'b0;
         r_out_end   <= 1'b0;
         r_out_abort <= 1'b0;
         if (inNewMsg) begin
            if (r_state == StCapture) begin
               r_out_end   <= 1'b1;
               r_out_abort <= 1'b1;
               r_out_len   <= r_len;
            end
            r_match_cnt <= '0;
            r_state     <= StIdle;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (inValid && isTagName) begin
                     r_idx   <= IdxW'(1);
                     r_mis   <= (in != w_first_char);
                     r_state <= StName;
                  end
               end
               StName: begin
                  if (inValid && isTagName) begin
                     r_mis <= r_mis || (r_idx >= IdxW'(NAME_LEN)) || (in != w_name_char);
                     if (r_idx != IdxW'(MAX_NAME)) r_idx <= r_idx + 1'b1;
                  end else if (inValid) begin
                     r_state <= w_name_ok ? StArmed : StIdle;
                  end
               end
               StArmed: begin
                  if (depthPush && (tagDepth == DepthIn)) begin
                     r_state <= StCapture;
                     // Content byte can arrive on the very cycle the opening tag is committed.
                     if (w_data_hit) begin
                        r_out_valid <= 1'b1;
                        r_out       <= in;
                        r_out_start <= 1'b1;
                        r_len       <= 16'd1;
                        r_first     <= 1'b0;
                     end else begin
                        r_len   <= '0;
                        r_first <= 1'b1;
                     end
                  end else if (depthPop || (inValid && !isTag)) begin
                     r_state <= StIdle;
                  end
               end
               StCapture: begin
                  if (depthPop && (tagDepth == DepthOut)) begin
                     r_out_end   <= 1'b1;
                     r_out_len   <= r_len;
                     r_match_cnt <= r_match_cnt + 1'b1;
                     r_state     <= StIdle;
                  end else if (w_data_hit) begin
                     r_out_valid <= 1'b1;
                     r_out       <= in;
                     r_out_start <= r_first;
                     r_first     <= 1'b0;
                     if (r_len != 16'hFFFF) r_len <= r_len + 1'b1;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign outValid   = r_out_valid;
   assign out        = r_out;
   assign outStart   = r_out_start;
   assign outEnd     = r_out_end;
   assign outAbort   = r_out_abort;
   assign outLen     = r_out_len;
   assign matchCount = r_match_cnt;

endmodule
